// File: rtl/bomb_timer_if.sv
// Controller <-> timer datapath bundle: load/enable commands in, tick, blink and BCD countdown out.
interface bomb_timer_if;
  logic       countLoadN;
  logic       countEnable;
  logic [3:0] loadTens;
  logic [3:0] loadOnes;
  logic       OneSecPulse;
  logic       duty50;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       timerEnd;

  modport master (
    output countLoadN, countEnable, loadTens, loadOnes,
    input  OneSecPulse, duty50, tens, ones, timerEnd
  );

  modport slave (
    input  countLoadN, countEnable, loadTens, loadOnes,
    output OneSecPulse, duty50, tens, ones, timerEnd
  );
endinterface

// File: rtl/bomb_timer_sequencer.sv
// One-second prescaler, blink square wave and 2-digit BCD countdown with a sticky expiry flag.
module bomb_timer_sequencer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic          clk,
  input  logic          resetN,
  bomb_timer_if.slave   bus
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          pulse_q, pulse_d;
  logic          duty_q,  duty_d;
  logic [3:0]    tens_q,  tens_d;
  logic [3:0]    ones_q,  ones_d;
  logic          end_q,   end_d;
  // Set by a load, cleared by reset: an unloaded 00 must not expire on its own.
  logic          armed_q, armed_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    if (!bus.countLoadN) presc_d = '0;
    pulse_d = (presc_d == PRESC_MAX);

    blink_d = (blink_q == BLINK_MAX) ? '0 : blink_q + BW'(1);
    duty_d  = (blink_q == BLINK_MAX) ? ~duty_q : duty_q;

    tens_d  = tens_q;
    ones_d  = ones_q;
    end_d   = end_q;
    armed_d = armed_q;

    if (!bus.countLoadN) begin
      tens_d  = clamp_bcd(bus.loadTens);
      ones_d  = clamp_bcd(bus.loadOnes);
      end_d   = 1'b0;
      armed_d = 1'b1;
    end else if (bus.countEnable && pulse_q && !end_q && armed_q) begin
      if (ones_q != 4'd0) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end
      // 01 and 00 both land on 00 with the flag raised on this same edge.
      if (tens_q == 4'd0 && ones_q <= 4'd1) begin
        ones_d = 4'd0;
        end_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc_q <= '0;
      blink_q <= '0;
      pulse_q <= 1'b0;
      duty_q  <= 1'b0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      end_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      pulse_q <= pulse_d;
      duty_q  <= duty_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      end_q   <= end_d;
      armed_q <= armed_d;
    end
  end

  assign bus.OneSecPulse = pulse_q;
  assign bus.duty50      = duty_q;
  assign bus.tens        = tens_q;
  assign bus.ones        = ones_q;
  assign bus.timerEnd    = end_q;

endmodule

// File: doc/bomb_timer_sequencer.md
Name: bomb_timer_sequencer

Overview:
Timing and countdown datapath that the bomb controller FSM sequences through countLoadN / countEnable.
- Generates the free-running one-second tick (OneSecPulse) and the 50%-duty blink square wave (duty50).
- Holds a 2-digit BCD countdown (tens/ones) for the seven-segment display.
- Raises a sticky timerEnd when the countdown expires.

Parameters:
CLK_HZ, 50_000_000, clk frequency; one second = CLK_HZ cycles.
BLINK_HZ, 2, duty50 frequency; CLK_HZ must be divisible by 2*BLINK_HZ.

Ports:
clk  in  1  system clock
resetN  in  1  reset, asynchronous, active-low
countLoadN  in  1  synchronous load, active-low, from the controller
countEnable  in  1  count-down enable, from the controller
loadTens  in  4  BCD tens digit to load
loadOnes  in  4  BCD ones digit to load
OneSecPulse  out  1  one-cycle tick once per second
duty50  out  1  square wave at BLINK_HZ
tens  out  4  current BCD tens digit
ones  out  4  current BCD ones digit
timerEnd  out  1  sticky countdown-expired flag

Behaviour:
- Reset (async, resetN=0), all registered:
  - prescaler=0, blink counter=0
  - OneSecPulse=0, duty50=0
  - tens=0, ones=0, timerEnd=0
- Prescaler:
  - Width $clog2(CLK_HZ); counts 0..CLK_HZ-1 and wraps to 0.
  - OneSecPulse=1 for exactly the one cycle in which prescaler==CLK_HZ-1.
  - Free-running regardless of countEnable, because the controller's pause/latency states consume it.
  - countLoadN=0 forces prescaler to 0, so the first tick comes CLK_HZ cycles after the last load cycle.
- Blink:
  - HALF = CLK_HZ/(2*BLINK_HZ).
  - Separate counter 0..HALF-1; duty50 toggles on each wrap.
  - Unaffected by load and enable.
- Digit inputs: any input digit >9 is clamped to 9 on load.
- Priority per clock edge: load > decrement > hold.
- Load (countLoadN=0):
  - tens/ones <= clamped inputs.
  - timerEnd <= 0.
  - Overrides countEnable and OneSecPulse in the same cycle.
- Decrement occurs when countLoadN=1, countEnable=1, OneSecPulse=1 and timerEnd=0:
  - ones!=0: ones--.
  - ones==0, tens!=0: ones<=9, tens--.
  - Pre-decrement value 01: result 00 and timerEnd<=1 on the same edge.
  - Pre-decrement value 00 (loaded as 00): value stays 00, timerEnd<=1.
- timerEnd:
  - Once set, it stays 1 and the digits freeze at 00.
  - Cleared only by load or reset.
- countEnable=0: digits hold. The partial second is not preserved, because the prescaler keeps running.
- countEnable toggling between ticks has no effect other than gating the next tick.
- Reset mid-count: immediate return to reset values. Counting restarts only after a new load.

Test Plan:
- CLK_HZ=8, BLINK_HZ=2, reset released at cycle 0 -> OneSecPulse high in cycles 7, 15, 23 only; duty50 toggles every 2 cycles starting 0; digits 00, timerEnd=0.
- Load 15 for 1 cycle, then countEnable=1 -> digits 15 for 8 cycles, then 14, 13 … 10, 09 (ones wraps to 9, tens decrements) … 01, 00. timerEnd rises on the 01->00 edge; the next 3 ticks leave 00/timerEnd=1.
- Loaded 12, enable dropped after the first tick (value 11) for 3 ticks, then raised -> value stays 11 while disabled, becomes 10 at the first tick after re-enable.
- countLoadN=0 asserted in the same cycle as OneSecPulse with countEnable=1, loading 37 from value 20 -> digits 37 (no decrement); prescaler restarts; next tick 8 cycles later gives 36. Also: loading 03 while timerEnd=1 -> timerEnd clears, digits 03.
- Load loadTens=4'hC, loadOnes=4'hA -> digits 99. Load 00, then enable -> timerEnd=1 at the first tick, digits stay 00.
- resetN pulsed low mid-count at value 07 -> all outputs 0 asynchronously (before the next edge); prescaler restarts; no decrement until a new load.
